// File: rtl/voice_allocator_if.sv
// Song-reader / note-player bus for the voice allocator.
// Latency: n/a (signal bundle only).
// Backpressure: ready is low while a chord is being allocated; new_note then sets overrun.
// Ports: play, beat, new_note, notes_in, durations_in (song side -> allocator);
//        ready, voice_note, voice_load, voice_busy, voice_done, steal, overrun (allocator -> players).
interface voice_allocator_if #(
   parameter int NOTE_WIDTH     = 6,
   parameter int DURATION_WIDTH = 6
);
   logic                        play;
   logic                        beat;
   logic                        new_note;
   logic [3*NOTE_WIDTH-1:0]     notes_in;
   logic [3*DURATION_WIDTH-1:0] durations_in;
   logic                        ready;
   logic [3*NOTE_WIDTH-1:0]     voice_note;
   logic [2:0]                  voice_load;
   logic [2:0]                  voice_busy;
   logic [2:0]                  voice_done;
   logic                        steal;
   logic                        overrun;

   modport master (
      output play, beat, new_note, notes_in, durations_in,
      input  ready, voice_note, voice_load, voice_busy, voice_done, steal, overrun
   );

   modport slave (
      input  play, beat, new_note, notes_in, durations_in,
      output ready, voice_note, voice_load, voice_busy, voice_done, steal, overrun
   );
endinterface

// File: rtl/voice_allocator.sv
// Assigns up to 3 chord slots onto 3 note-player voices, stealing the voice closest to done.
// Latency: new_note at edge E; slot i written at edge E+1+i; voice_load/steal visible after that edge.
// Backpressure: ready=0 for the 3 allocation cycles; new_note then is dropped and overrun sticks.
// Ports: clk, reset_n (async, active low); bus = voice_allocator_if.slave.
//        Packed fields are {slot0/v0, slot1/v1, slot2/v2}, MSB first.
module voice_allocator #(
   parameter int NOTE_WIDTH     = 6,
   parameter int DURATION_WIDTH = 6
) (
   input logic              clk,
   input logic              reset_n,
   voice_allocator_if.slave bus
);
   localparam int NW = NOTE_WIDTH;
   localparam int DW = DURATION_WIDTH;
   localparam int NV = 3;

   typedef enum logic [1:0] {IDLE, ALLOC0, ALLOC1, ALLOC2} state_t;

   state_t           state, state_next;
   logic [3*NW-1:0]  notes_lat;
   logic [3*DW-1:0]  durs_lat;
   logic [DW-1:0]    count [NV];
   logic [NW-1:0]    note  [NV];
   logic [NV-1:0]    load_r, done_r;
   logic             steal_r, overrun_r;

   logic             latch, alloc;
   logic [1:0]       slot;
   logic [NW-1:0]    slot_note;
   logic [DW-1:0]    slot_dur;
   logic             any_free, take, pick_steal;
   logic [1:0]       free_idx, min_idx, pick;
   logic [DW-1:0]    min_cnt;

   // Sequencer: one slot per cycle, never aborted once started.
   always_comb begin
      state_next = state;
      latch      = 1'b0;
      alloc      = 1'b0;
      slot       = 2'd0;
      case (state)
         IDLE: begin
            if (bus.new_note && bus.play) begin
               latch      = 1'b1;
               state_next = ALLOC0;
            end
         end
         ALLOC0: begin
            alloc      = 1'b1;
            slot       = 2'd0;
            state_next = ALLOC1;
         end
         ALLOC1: begin
            alloc      = 1'b1;
            slot       = 2'd1;
            state_next = ALLOC2;
         end
         ALLOC2: begin
            alloc      = 1'b1;
            slot       = 2'd2;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      slot_note = '0;
      slot_dur  = '0;
      case (slot)
         2'd0:    begin slot_note = notes_lat[3*NW-1:2*NW]; slot_dur = durs_lat[3*DW-1:2*DW]; end
         2'd1:    begin slot_note = notes_lat[2*NW-1:NW];   slot_dur = durs_lat[2*DW-1:DW];   end
         default: begin slot_note = notes_lat[NW-1:0];      slot_dur = durs_lat[DW-1:0];      end
      endcase
   end

   // Voice choice works on the registered counts, so earlier slots of the
   // same chord are already reflected. Descending scan leaves the lowest
   // free index; strict '<' keeps the lowest index on count ties.
   always_comb begin
      any_free = 1'b0;
      free_idx = 2'd0;
      for (int v = NV - 1; v >= 0; v--) begin
         if (count[v] == '0) begin
            any_free = 1'b1;
            free_idx = 2'(v);
         end
      end
      min_idx = 2'd0;
      min_cnt = count[0];
      for (int v = 1; v < NV; v++) begin
         if (count[v] < min_cnt) begin
            min_cnt = count[v];
            min_idx = 2'(v);
         end
      end
      take       = alloc && (slot_note != '0) && (slot_dur != '0);
      pick       = any_free ? free_idx : min_idx;
      pick_steal = take && !any_free;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         notes_lat <= '0;
         durs_lat  <= '0;
         load_r    <= '0;
         done_r    <= '0;
         steal_r   <= 1'b0;
         overrun_r <= 1'b0;
         for (int v = 0; v < NV; v++) begin
            count[v] <= '0;
            note[v]  <= '0;
         end
      end else begin
         state   <= state_next;
         load_r  <= '0;
         done_r  <= '0;
         steal_r <= pick_steal;
         if (latch) begin
            notes_lat <= bus.notes_in;
            durs_lat  <= bus.durations_in;
         end
         if (bus.new_note && bus.play && (state != IDLE))
            overrun_r <= 1'b1;
         for (int v = 0; v < NV; v++) begin
            // A load on the same edge as a beat wins: no decrement, no done.
            if (take && (pick == 2'(v))) begin
               count[v]         <= slot_dur;
               note[v]          <= slot_note;
               load_r[NV-1-v]   <= 1'b1;
            end else if (bus.beat && bus.play && (count[v] != '0)) begin
               count[v] <= count[v] - DW'(1);
               if (count[v] == DW'(1)) begin
                  done_r[NV-1-v] <= 1'b1;
                  note[v]        <= '0;
               end
            end
         end
      end
   end

   assign bus.ready      = (state == IDLE);
   assign bus.voice_note = {note[0], note[1], note[2]};
   assign bus.voice_busy = {count[0] != '0, count[1] != '0, count[2] != '0};
   assign bus.voice_load = load_r;
   assign bus.voice_done = done_r;
   assign bus.steal      = steal_r;
   assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_voice_allocator.sv
// Randomised + directed bench for voice_allocator with a queue-based reference model.
module tb_voice_allocator;
   logic clk = 1'b0;
   logic reset_n = 1'b0;

   voice_allocator_if #(.NOTE_WIDTH(6), .DURATION_WIDTH(6)) va ();
   voice_allocator #(.NOTE_WIDTH(6), .DURATION_WIDTH(6)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (va)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Reference model: voice counts/notes, slots still waiting for a voice.
   typedef struct { int note; int dur; } slot_t;
   typedef struct {
      int         stamp;
      logic [2:0] load;
      logic [2:0] done;
      logic       steal;
      logic [17:0] notes;
      logic [2:0] busy;
   } ev_t;

   int    m_cnt [3];
   int    m_nt  [3];
   bit    m_ovr;
   slot_t pend  [$];
   ev_t   exp_q [$];
   ev_t   e;

   task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [17:0] exp_notes();
      return {6'(m_nt[0]), 6'(m_nt[1]), 6'(m_nt[2])};
   endfunction

   function automatic logic [2:0] exp_busy();
      return {m_cnt[0] != 0, m_cnt[1] != 0, m_cnt[2] != 0};
   endfunction

   task automatic model_reset();
      for (int v = 0; v < 3; v++) begin
         m_cnt[v] = 0;
         m_nt[v]  = 0;
      end
      m_ovr = 1'b0;
      pend.delete();
      exp_q.delete();
   endtask

   // Advances the model across the next clock edge for the given inputs.
   task automatic model_step(input bit nn, input bit pl, input bit bt,
                             input logic [17:0] ni, input logic [17:0] di);
      int lv;
      bit stl, rdy_pre;
      logic [2:0] ld, dn;
      slot_t s;
      ev_t ev;
      lv = -1; stl = 1'b0; ld = '0; dn = '0;
      s = '{note: 0, dur: 0};
      rdy_pre = (pend.size() == 0);
      if (!rdy_pre) begin
         s = pend.pop_front();
         if (s.note != 0 && s.dur != 0) begin
            for (int v = 0; v < 3; v++)
               if (lv < 0 && m_cnt[v] == 0) lv = v;
            if (lv < 0) begin
               stl = 1'b1;
               lv  = 0;
               for (int v = 1; v < 3; v++)
                  if (m_cnt[v] < m_cnt[lv]) lv = v;
            end
         end
      end
      if (bt && pl) begin
         for (int v = 0; v < 3; v++) begin
            if (v != lv && m_cnt[v] > 0) begin
               m_cnt[v]--;
               if (m_cnt[v] == 0) begin
                  dn[2-v] = 1'b1;
                  m_nt[v] = 0;
               end
            end
         end
      end
      if (lv >= 0) begin
         m_cnt[lv] = s.dur;
         m_nt[lv]  = s.note;
         ld[2-lv]  = 1'b1;
      end
      if (nn && pl) begin
         if (rdy_pre) begin
            for (int i = 0; i < 3; i++)
               pend.push_back('{note: int'(ni[(2-i)*6 +: 6]), dur: int'(di[(2-i)*6 +: 6])});
         end else begin
            m_ovr = 1'b1;
         end
      end
      if (ld != 0 || dn != 0) begin
         ev.stamp = cyc + 1;
         ev.load  = ld;
         ev.done  = dn;
         ev.steal = stl;
         ev.notes = exp_notes();
         ev.busy  = exp_busy();
         exp_q.push_back(ev);
      end
   endtask

   // One cycle of stimulus: check steady outputs, drive, model, advance.
   task automatic tick(input bit nn, input bit pl, input bit bt,
                       input logic [17:0] ni, input logic [17:0] di);
      chk("ready", {17'b0, va.ready}, {17'b0, pend.size() == 0});
      chk("overrun", {17'b0, va.overrun}, {17'b0, m_ovr});
      chk("voice_busy", {15'b0, va.voice_busy}, {15'b0, exp_busy()});
      chk("voice_note", va.voice_note, exp_notes());
      va.new_note     = nn;
      va.play         = pl;
      va.beat         = bt;
      va.notes_in     = ni;
      va.durations_in = di;
      model_step(nn, pl, bt, ni, di);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b1, 1'b0, 18'h0, 18'h0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every event cycle the DUT shows must match the next queued expectation.
   always @(negedge clk) begin
      if (reset_n) begin
         if (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event: expected at cycle %0d, now %0d", exp_q[0].stamp, cyc);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
            e = exp_q.pop_front();
            chk("ev_voice_load", {15'b0, va.voice_load}, {15'b0, e.load});
            chk("ev_voice_done", {15'b0, va.voice_done}, {15'b0, e.done});
            chk("ev_steal", {17'b0, va.steal}, {17'b0, e.steal});
            chk("ev_voice_note", va.voice_note, e.notes);
            chk("ev_voice_busy", {15'b0, va.voice_busy}, {15'b0, e.busy});
         end else if (va.voice_load != 0 || va.voice_done != 0 || va.steal) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: load=%b done=%b steal=%b expected none (cycle %0d)",
                     va.voice_load, va.voice_done, va.steal, cyc);
         end
      end
   end

   int low_cnt;

   initial begin
      va.play = 1'b0; va.beat = 1'b0; va.new_note = 1'b0;
      va.notes_in = '0; va.durations_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {17'b0, va.ready}, 18'd1);
      chk("rst_overrun", {17'b0, va.overrun}, 18'd0);
      chk("rst_voice_note", va.voice_note, 18'd0);
      chk("rst_voice_busy", {15'b0, va.voice_busy}, 18'd0);
      chk("rst_voice_load", {15'b0, va.voice_load}, 18'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic chord onto three free voices.
      tick(1'b1, 1'b1, 1'b0, {6'd5, 6'd9, 6'd12}, {6'd4, 6'd2, 6'd8});
      idle(4);
      chk("t1_notes", va.voice_note, {6'd5, 6'd9, 6'd12});

      // Two beats finish voice 1.
      tick(1'b0, 1'b1, 1'b1, 18'h0, 18'h0);
      idle(1);
      tick(1'b0, 1'b1, 1'b1, 18'h0, 18'h0);
      idle(1);
      chk("t2_busy", {15'b0, va.voice_busy}, {15'b0, 3'b101});
      chk("t2_v1_note", {12'b0, va.voice_note[11:6]}, 18'd0);

      // Steal: counts {3,1,1}, voice 1 is the lowest-index minimum.
      do_reset();
      tick(1'b1, 1'b1, 1'b0, {6'd1, 6'd2, 6'd3}, {6'd3, 6'd1, 6'd1});
      idle(4);
      tick(1'b1, 1'b1, 1'b0, {6'd7, 6'd0, 6'd0}, {6'd5, 6'd0, 6'd0});
      idle(4);
      chk("t3_notes", va.voice_note, {6'd1, 6'd7, 6'd3});

      // Rest and zero-duration slots load nothing; ready low exactly 3 cycles.
      do_reset();
      tick(1'b1, 1'b1, 1'b0, {6'd0, 6'd9, 6'd0}, {6'd4, 6'd0, 6'd3});
      low_cnt = 0;
      repeat (5) begin
         if (!va.ready) low_cnt++;
         idle(1);
      end
      chk("t4_ready_low", 18'(low_cnt), 18'd3);
      chk("t4_busy", {15'b0, va.voice_busy}, 18'd0);

      // Back-to-back new_note: second dropped, overrun sticks.
      tick(1'b1, 1'b1, 1'b0, {6'd10, 6'd11, 6'd12}, {6'd2, 6'd3, 6'd4});
      tick(1'b1, 1'b1, 1'b0, {6'd20, 6'd21, 6'd22}, {6'd5, 6'd5, 6'd5});
      idle(4);
      chk("t5_overrun", {17'b0, va.overrun}, 18'd1);
      chk("t5_notes", va.voice_note, {6'd10, 6'd11, 6'd12});

      // Asynchronous reset while in ALLOC1.
      do_reset();
      tick(1'b1, 1'b1, 1'b0, {6'd5, 6'd9, 6'd12}, {6'd4, 6'd2, 6'd8});
      idle(1);
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("t6_ready", {17'b0, va.ready}, 18'd1);
      chk("t6_voice_note", va.voice_note, 18'd0);
      chk("t6_voice_busy", {15'b0, va.voice_busy}, 18'd0);
      chk("t6_voice_load", {15'b0, va.voice_load}, 18'd0);
      chk("t6_overrun", {17'b0, va.overrun}, 18'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      idle(6);

      // Randomised traffic including play gating, beats during allocation and steals.
      do_reset();
      for (int n = 0; n < 500; n++) begin
         logic [17:0] ni, di;
         for (int i = 0; i < 3; i++) begin
            ni[i*6 +: 6] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            case ($urandom_range(0, 9))
               0:       di[i*6 +: 6] = 6'd0;
               1:       di[i*6 +: 6] = 6'd63;
               default: di[i*6 +: 6] = 6'($urandom_range(1, 6));
            endcase
         end
         tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0,
              $urandom_range(0, 2) == 0, ni, di);
      end
      idle(4);
      chk("queue_drained", 18'(exp_q.size()), 18'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
